// File: rtl/fsm_bn_span.sv
`default_nettype none
// ============================================================================
// Module   : fsm_bn_span
// Brief    : Sequencer for N_EDGE Bresenham edge walkers feeding the Z-buffer
//            span filler. Edge 0 (long edge) is paired in turn with short
//            edges 1..N_EDGE-1. Each walker step is followed by a span-fill
//            request; spans are counted and end of conversion is pulsed.
// Options  : FSM_BN_TMO_EN - watchdog on every wait state; on expiry the
//            block pulses err together with eoc and returns to idle.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_bn_span #(
   parameter int N_EDGE = 3,
   parameter int CNT_W  = 12,
   parameter int TMO_W  = 8,
   localparam int SEL_W = ($clog2(N_EDGE) > 1) ? $clog2(N_EDGE) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_1,
   output logic              ack_1,
   output logic              req_init,
   input  logic              ack_init,
   output logic              init_br,
   output logic [SEL_W-1:0]  edge_sel,
   output logic [N_EDGE-1:0] req_step,
   input  logic [N_EDGE-1:0] ack_step,
   input  logic [N_EDGE-1:0] eol,
   output logic              req_2,
   input  logic              ack_2,
   output logic [CNT_W-1:0]  span_cnt,
   output logic              eoc,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE         = 4'd0,
      S_REQ_INIT     = 4'd1,
      S_W_INIT       = 4'd2,
      S_INIT_BR      = 4'd3,
      S_W_PAIR       = 4'd4,
      S_FILL_FIRST   = 4'd5,
      S_W_FILL_FIRST = 4'd6,
      S_STEP         = 4'd7,
      S_W_STEP       = 4'd8,
      S_REQ_FILL     = 4'd9,
      S_W_FILL       = 4'd10,
      S_NEXT_STAGE   = 4'd11,
      S_DONE         = 4'd12
`ifdef FSM_BN_TMO_EN
      ,S_TMO         = 4'd13
`endif
   } state_t;

   localparam logic [CNT_W-1:0] c_span_max = '1;
   localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(N_EDGE - 1);

   state_t             r_state;
   state_t             w_next;
   logic               r_first;      // high in the first cycle spent in a state
   logic               r_ack_1;
   logic [CNT_W-1:0]   r_span;
   logic [SEL_W-1:0]   r_stage;      // stage index; short edge is stage + 1
   logic [SEL_W-1:0]   w_sel;
   logic               w_pair_idle;
   logic               w_eol_sel;
   logic               w_last_sel;
   logic               w_req_init;
   logic               w_init_br;
   logic               w_step_pulse;
   logic               w_req_2;
   logic               w_eoc;

   assign w_sel       = r_stage + SEL_W'(1);
   assign w_pair_idle = !ack_step[0] && !ack_step[w_sel];
   assign w_eol_sel   = eol[w_sel];
   assign w_last_sel  = (w_sel == c_last_sel);

`ifdef FSM_BN_TMO_EN
   localparam logic [TMO_W-1:0] c_tmo_trip = TMO_W'((1 << TMO_W) - 2);

   logic [TMO_W-1:0]   r_tmo;
   logic               w_in_wait;
   logic               w_err;

   assign w_in_wait = (r_state == S_W_INIT)       || (r_state == S_W_PAIR) ||
                      (r_state == S_W_FILL_FIRST) || (r_state == S_W_STEP) ||
                      (r_state == S_W_FILL);

   // Watchdog: restarts on every state change, advances while waiting
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tmo <= '0;
      end else if (w_next != r_state) begin
         r_tmo <= '0;
      end else if (w_in_wait) begin
         r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   assign err = w_err;
`else
   assign err = 1'b0;
`endif

   // Next-state and Moore pulse decode; waits ignore busy in their first cycle
   always_comb begin
      w_next       = r_state;
      w_req_init   = 1'b0;
      w_init_br    = 1'b0;
      w_step_pulse = 1'b0;
      w_req_2      = 1'b0;
      w_eoc        = 1'b0;
`ifdef FSM_BN_TMO_EN
      w_err        = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!req_1) w_next = S_REQ_INIT;
         end
         S_REQ_INIT: begin
            w_req_init = 1'b1;
            w_next     = S_W_INIT;
         end
         S_W_INIT: begin
            if (!r_first && !ack_init) w_next = S_INIT_BR;
         end
         S_INIT_BR: begin
            w_init_br = 1'b1;
            w_next    = S_W_PAIR;
         end
         S_W_PAIR: begin
            if (!r_first && w_pair_idle) w_next = S_FILL_FIRST;
         end
         S_FILL_FIRST: begin
            w_req_2 = 1'b1;
            w_next  = S_W_FILL_FIRST;
         end
         S_W_FILL_FIRST: begin
            if (!r_first && !ack_2) w_next = S_STEP;
         end
         S_STEP: begin
            w_step_pulse = 1'b1;
            w_next       = S_W_STEP;
         end
         S_W_STEP: begin
            if (!r_first && w_pair_idle) w_next = S_REQ_FILL;
         end
         S_REQ_FILL: begin
            w_req_2 = 1'b1;
            w_next  = S_W_FILL;
         end
         S_W_FILL: begin
            // Long edge finishing, or the last short edge finishing, ends the
            // triangle; this also covers both edges ending on the same step.
            if (!r_first && !ack_2 && w_pair_idle) begin
               if (eol[0] || (w_eol_sel && w_last_sel)) begin
                  w_next = S_DONE;
               end else if (w_eol_sel) begin
                  w_next = S_NEXT_STAGE;
               end else begin
                  w_next = S_STEP;
               end
            end
         end
         S_NEXT_STAGE: begin
            w_next = S_REQ_INIT;
         end
         S_DONE: begin
            w_eoc  = 1'b1;
            w_next = S_IDLE;
         end
`ifdef FSM_BN_TMO_EN
         S_TMO: begin
            w_err  = 1'b1;
            w_eoc  = 1'b1;
            w_next = S_IDLE;
         end
`endif
         default: begin
            w_next = S_IDLE;
         end
      endcase
`ifdef FSM_BN_TMO_EN
      if (w_in_wait && (w_next == r_state) && (r_tmo == c_tmo_trip)) begin
         w_next = S_TMO;
      end
`endif
   end

   // State register and first-cycle marker for the wait states
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_first <= 1'b1;
      end else begin
         r_state <= w_next;
         r_first <= (w_next != r_state);
      end
   end

   // ack_1 rises one edge after the first REQ_INIT and falls on return to IDLE
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ack_1 <= 1'b0;
      end else begin
         r_ack_1 <= (w_next != S_IDLE) && (r_state != S_IDLE);
      end
   end

   // Span counter: cleared on start, saturating increment per fill request
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_span <= '0;
      end else if ((r_state == S_IDLE) && !req_1) begin
         r_span <= '0;
      end else if (w_req_2 && (r_span != c_span_max)) begin
         r_span <= r_span + CNT_W'(1);
      end
   end

   // Stage register: restarts at the first short edge, advances per stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stage <= '0;
      end else if ((r_state == S_IDLE) && !req_1) begin
         r_stage <= '0;
      end else if (r_state == S_NEXT_STAGE) begin
         r_stage <= r_stage + SEL_W'(1);
      end
   end

   // Step pulse reaches only the long edge and the active short edge
   for (genvar gi = 0; gi < N_EDGE; gi++) begin : g_step
      assign req_step[gi] = w_step_pulse && ((gi == 0) || (w_sel == SEL_W'(gi)));
   end

   assign ack_1    = r_ack_1;
   assign req_init = w_req_init;
   assign init_br  = w_init_br;
   assign edge_sel = w_sel;
   assign req_2    = w_req_2;
   assign span_cnt = r_span;
   assign eoc      = w_eoc;

endmodule
`default_nettype wire

// File: tb/tb_fsm_bn_span.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_bn_span
// Brief    : Bench for fsm_bn_span. Two instances: a three-edge block and a
//            two-edge block with a narrow span counter. Walkers, setup and
//            filler are emulated with random busy times and lengths; the
//            expected span count, stage count and step count of each triangle
//            come from an arithmetic walk over the edge lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_bn_span;

   logic clk;
   logic rst;

   // three-edge instance
   logic        req_1_a, ack_1_a, req_init_a, ack_init_a, init_br_a;
   logic [1:0]  edge_sel_a;
   logic [2:0]  req_step_a, ack_step_a, eol_a;
   logic        req_2_a, ack_2_a, eoc_a, err_a;
   logic [11:0] span_a;

   // two-edge instance, 3-bit span counter
   logic        req_1_b, ack_1_b, req_init_b, ack_init_b, init_br_b;
   logic [0:0]  edge_sel_b;
   logic [1:0]  req_step_b, ack_step_b, eol_b;
   logic        req_2_b, ack_2_b, eoc_b, err_b;
   logic [2:0]  span_b;

   fsm_bn_span #(.N_EDGE(3), .CNT_W(12), .TMO_W(8)) dut_a (
      .clk(clk), .rst(rst), .req_1(req_1_a), .ack_1(ack_1_a),
      .req_init(req_init_a), .ack_init(ack_init_a), .init_br(init_br_a),
      .edge_sel(edge_sel_a), .req_step(req_step_a), .ack_step(ack_step_a),
      .eol(eol_a), .req_2(req_2_a), .ack_2(ack_2_a), .span_cnt(span_a),
      .eoc(eoc_a), .err(err_a));

   fsm_bn_span #(.N_EDGE(2), .CNT_W(3), .TMO_W(8)) dut_b (
      .clk(clk), .rst(rst), .req_1(req_1_b), .ack_1(ack_1_b),
      .req_init(req_init_b), .ack_init(ack_init_b), .init_br(init_br_b),
      .edge_sel(edge_sel_b), .req_step(req_step_b), .ack_step(ack_step_b),
      .eol(eol_b), .req_2(req_2_b), .ack_2(ack_2_b), .span_cnt(span_b),
      .eoc(eoc_b), .err(err_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // environment state for instance A
   int len_a[3];
   int tot_a, ss_a, st_a, n_init_a, n_eoc_a, viol_a, bi_a, b2_a;
   int bs_a[3];
   int ilo, ihi, slo, shi, flo, fhi;
   // environment state for instance B
   int len_b[2];
   int tot_b, ss_b, n_init_b, n_eoc_b, viol_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected result of one triangle from edge lengths: each stage steps until
   // the long edge or the active short edge runs out, plus one re-filled span.
   function automatic void model(input int n, input int cmax, input int l0, input int l1,
                                 input int l2, output int sp, output int stg,
                                 output int stp, output int sel);
      int len[3];
      int tot, s, ns;
      bit fin;
      len = '{l0, l1, l2};
      tot = 0; s = 1; sp = 0; stg = 0; fin = 1'b0;
      while (!fin) begin
         stg++;
         ns  = (len[s] < l0 - tot) ? len[s] : l0 - tot;
         sp += 1 + ns;
         tot += ns;
         if (tot >= l0 || s == n - 1) fin = 1'b1;
         else s++;
      end
      stp = tot;
      sel = s;
      if (sp > cmax) sp = cmax;
   endfunction

   task automatic set_busy(input int a, input int b, input int c, input int d,
                           input int e, input int f);
      ilo = a; ihi = b; slo = c; shi = d; flo = e; fhi = f;
   endtask

   // One cycle of emulated slaves for A, called at the falling edge
   task automatic env_a();
      if (req_init_a === 1'b1 && ack_init_a) viol_a++;
      if (req_2_a === 1'b1 && (ack_2_a || ack_step_a[0] || ack_step_a[st_a])) viol_a++;
      if (req_step_a !== 3'b000) begin
         if (ack_2_a || ack_step_a[0] || ack_step_a[st_a]) viol_a++;
         if (st_a == 0 || req_step_a[0] !== 1'b1 || req_step_a[st_a] !== 1'b1) viol_a++;
         for (int k = 1; k < 3; k++) if (k != st_a && req_step_a[k] !== 1'b0) viol_a++;
      end
      if (req_init_a === 1'b1) begin
         n_init_a++;
         bi_a = $urandom_range(ihi, ilo);
      end else if (bi_a > 0) bi_a--;
      if (init_br_a === 1'b1) begin
         if (st_a < 2) st_a++;
         ss_a = 0;
      end
      if (req_step_a[0] === 1'b1) tot_a++;
      if (st_a > 0 && req_step_a[st_a] === 1'b1) ss_a++;
      for (int k = 0; k < 3; k++) begin
         if (req_step_a[k] === 1'b1) bs_a[k] = $urandom_range(shi, slo);
         else if (bs_a[k] > 0) bs_a[k]--;
      end
      if (req_2_a === 1'b1) b2_a = $urandom_range(fhi, flo);
      else if (b2_a > 0) b2_a--;
      if (eoc_a === 1'b1) n_eoc_a++;
      ack_init_a = (bi_a > 0);
      ack_2_a    = (b2_a > 0);
      for (int k = 0; k < 3; k++) ack_step_a[k] = (bs_a[k] > 0);
      eol_a[0] = (tot_a >= len_a[0]);
      for (int k = 1; k < 3; k++)
         eol_a[k] = (k == st_a) ? (ss_a >= len_a[k]) : 1'($urandom_range(1, 0));
   endtask

   task automatic run_tri_a(input string tag, input int l0, input int l1, input int l2);
      int e_sp, e_stg, e_stp, e_sel;
      bit got;
      model(3, 4095, l0, l1, l2, e_sp, e_stg, e_stp, e_sel);
      len_a = '{l0, l1, l2};
      tot_a = 0; ss_a = 0; st_a = 0; n_init_a = 0; n_eoc_a = 0; viol_a = 0;
      bi_a = 0; b2_a = 0; bs_a = '{0, 0, 0};
      got = 1'b0;
      req_1_a = 1'b0;
      for (int c = 0; c < 4000 && !got; c++) begin
         @(negedge clk);
         env_a();
         if (req_init_a === 1'b1) req_1_a = 1'b1;
         if (eoc_a === 1'b1) begin
            got = 1'b1;
            chk({tag, ":ack1_at_eoc"}, 32'(ack_1_a), 32'd1);
         end
      end
      chk({tag, ":eoc_seen"}, 32'(got), 32'd1);
      @(negedge clk);
      env_a();
      chk({tag, ":ack1_after"}, 32'(ack_1_a), 32'd0);
      chk({tag, ":span"}, 32'(span_a), 32'(e_sp));
      chk({tag, ":edge_sel"}, 32'(edge_sel_a), 32'(e_sel));
      chk({tag, ":inits"}, 32'(n_init_a), 32'(e_stg));
      chk({tag, ":steps"}, 32'(tot_a), 32'(e_stp));
      chk({tag, ":eocs"}, 32'(n_eoc_a), 32'd1);
      chk({tag, ":protocol"}, 32'(viol_a), 32'd0);
      chk({tag, ":err"}, 32'(err_a), 32'd0);
   endtask

   // One cycle of emulated slaves for B (never busy)
   task automatic env_b();
      if (req_step_b !== 2'b00 && req_step_b !== 2'b11) viol_b++;
      if (req_init_b === 1'b1) n_init_b++;
      if (init_br_b === 1'b1) ss_b = 0;
      if (req_step_b[0] === 1'b1) tot_b++;
      if (req_step_b[1] === 1'b1) ss_b++;
      if (eoc_b === 1'b1) n_eoc_b++;
      eol_b[0] = (tot_b >= len_b[0]);
      eol_b[1] = (ss_b >= len_b[1]);
   endtask

   task automatic run_tri_b(input string tag, input int l0, input int l1);
      int e_sp, e_stg, e_stp, e_sel;
      bit got;
      model(2, 7, l0, l1, 1, e_sp, e_stg, e_stp, e_sel);
      len_b = '{l0, l1};
      tot_b = 0; ss_b = 0; n_init_b = 0; n_eoc_b = 0; viol_b = 0;
      got = 1'b0;
      req_1_b = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge clk);
         env_b();
         if (req_init_b === 1'b1) req_1_b = 1'b1;
         if (eoc_b === 1'b1) got = 1'b1;
      end
      chk({tag, ":eoc_seen"}, 32'(got), 32'd1);
      @(negedge clk);
      env_b();
      chk({tag, ":ack1_after"}, 32'(ack_1_b), 32'd0);
      chk({tag, ":span"}, 32'(span_b), 32'(e_sp));
      chk({tag, ":edge_sel"}, 32'(edge_sel_b), 32'(e_sel));
      chk({tag, ":inits"}, 32'(n_init_b), 32'(e_stg));
      chk({tag, ":steps"}, 32'(tot_b), 32'(e_stp));
      chk({tag, ":eocs"}, 32'(n_eoc_b), 32'd1);
      chk({tag, ":protocol"}, 32'(viol_b), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit got;
      rst = 1'b0;
      req_1_a = 1'b1; ack_init_a = 1'b0; ack_step_a = '0; eol_a = '0; ack_2_a = 1'b0;
      req_1_b = 1'b1; ack_init_b = 1'b0; ack_step_b = '0; eol_b = '0; ack_2_b = 1'b0;
      set_busy(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_a:outputs", 32'({ack_1_a, req_init_a, init_br_a, req_step_a, req_2_a, eoc_a, err_a}), 32'd0);
      chk("rst_a:span", 32'(span_a), 32'd0);
      chk("rst_a:edge_sel", 32'(edge_sel_a), 32'd1);
      chk("rst_b:outputs", 32'({ack_1_b, req_init_b, init_br_b, req_step_b, req_2_b, eoc_b, err_b}), 32'd0);
      chk("rst_b:edge_sel", 32'(edge_sel_b), 32'd1);
      rst = 1'b1;
      @(negedge clk);

      // two stages, walkers never busy: 1+4 then 1+7 spans
      run_tri_a("two_stage", 11, 4, 20);
      // long and short edge end on the same step
      run_tri_a("same_eol", 3, 3, 5);
      // slow filler and walkers
      set_busy(0, 1, 2, 2, 5, 5);
      run_tri_a("busy", 6, 3, 4);

      // randomized triangles and busy times
      for (int i = 0; i < 12; i++) begin
         set_busy(0, $urandom_range(3, 0), 0, $urandom_range(3, 0), 0, $urandom_range(4, 0));
         run_tri_a($sformatf("rand%0d", i), $urandom_range(12, 1),
                   $urandom_range(8, 1), $urandom_range(8, 1));
      end

      // two-edge block: last short edge ends the triangle, and saturation
      run_tri_b("n2_short", 20, 3);
      run_tri_b("n2_long", 2, 5);
      run_tri_b("n2_sat", 10, 10);

      // reset while waiting on a step
      set_busy(0, 0, 2, 2, 0, 0);
      len_a = '{50, 50, 50};
      tot_a = 0; ss_a = 0; st_a = 0; bi_a = 0; b2_a = 0; bs_a = '{0, 0, 0};
      got = 1'b0;
      req_1_a = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         env_a();
         if (req_init_a === 1'b1) req_1_a = 1'b1;
         if (req_step_a !== 3'b000) got = 1'b1;
      end
      chk("mid_rst:step_seen", 32'(got), 32'd1);
      @(negedge clk);
      env_a();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst:outputs", 32'({ack_1_a, req_init_a, init_br_a, req_step_a, req_2_a, eoc_a, err_a}), 32'd0);
      chk("mid_rst:span", 32'(span_a), 32'd0);
      chk("mid_rst:edge_sel", 32'(edge_sel_a), 32'd1);
      rst = 1'b1;
      set_busy(0, 1, 0, 1, 0, 1);
      run_tri_a("after_rst", 5, 2, 3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
